// File: rtl/copy_engine_sink_if.sv
// Copy-engine side bus: pixel writes, engine control and sprite source fetch.
interface copy_engine_sink_if;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic [1:0]  palette_index;
  logic        engine_execute;
  logic        engine_done;
  logic        current_frame;
  logic [19:0] src_addr;
  logic [15:0] src_data;

  // Engine drives requests and receives the displayed frame and source word.
  modport master (
    output program_x, program_y, program_data, program_write,
    output palette_index, engine_execute, engine_done, src_addr,
    input  current_frame, src_data
  );

  modport slave (
    input  program_x, program_y, program_data, program_write,
    input  palette_index, engine_execute, engine_done, src_addr,
    output current_frame, src_data
  );
endinterface

// File: rtl/copy_engine_sink.sv
// Pixel sink for the copy engine: buffers pixel writes in a small FIFO, drains
// them into the back frame of a double-buffered SRAM around VGA reads, and
// flips the displayed frame once the engine reports a finished frame.
module copy_engine_sink (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  copy_engine_sink_if.slave eng,
  output logic [19:0]       rom_addr,
  input  logic [15:0]       rom_q,
  input  logic              vga_busy,
  output logic [19:0]       sram_addr,
  output logic [15:0]       sram_wdata,
  output logic              sram_we_n,
  output logic [1:0]        palette_sel,
  output logic              overflow
);

  localparam int unsigned Depth = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FLIP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [35:0] mem [Depth];
  logic [2:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]  count_q;
  logic        full, empty, in_range, push, pop, lost;
  logic        exec_prev_q, done_prev_q, exec_rise, done_rise;
  logic        flip_pending_q, frame_q, overflow_q;
  logic [1:0]  palette_latch_q, palette_sel_q;
  logic [15:0] src_data_q;
  logic [19:0] sram_addr_q;
  logic [15:0] sram_wdata_q;
  logic        sram_we_n_q;
  logic [35:0] head;
  logic [9:0]  head_x, head_y;
  logic [18:0] pix_addr;

  assign rom_addr          = eng.src_addr;
  assign eng.src_data      = src_data_q;
  assign eng.current_frame = frame_q;
  assign sram_addr         = sram_addr_q;
  assign sram_wdata        = sram_wdata_q;
  assign sram_we_n         = sram_we_n_q;
  assign palette_sel       = palette_sel_q;
  assign overflow          = overflow_q;

  assign full      = (count_q == 4'(Depth));
  assign empty     = (count_q == 4'd0);
  assign in_range  = (eng.program_x < 10'd640) && (eng.program_y < 10'd480);
  assign exec_rise = eng.engine_execute & ~exec_prev_q;
  assign done_rise = eng.engine_done & ~done_prev_q;

  // The SRAM is never popped during a flip cycle or while VGA owns it.
  assign pop  = (state_q != ST_FLIP) && !empty && !vga_busy;
  // A full FIFO still accepts a write in the same cycle it pops.
  assign push = eng.program_write && in_range && (!full || pop);
  assign lost = eng.program_write && in_range && full && !pop;

  assign head   = mem[rd_ptr_q];
  assign head_x = head[35:26];
  assign head_y = head[25:16];
  // y*640 + x via shifts; fits in 19 bits for in-range coordinates.
  assign pix_addr = {head_y, 9'b0} + {2'b0, head_y, 7'b0} + {9'b0, head_x};

  // Next-state decode for the drain/flip sequencer.
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (pop)                          state_d = ST_WRITE;
        else if (flip_pending_q && empty) state_d = ST_FLIP;
        else                              state_d = ST_IDLE;
      end
      ST_WRITE: state_d = pop ? ST_WRITE : ST_IDLE;
      ST_FLIP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr_q] <= {eng.program_x, eng.program_y, eng.program_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_q + {3'b0, push} - {3'b0, pop};
    end
  end

  // Sequencer state, SRAM write port and frame flip.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= ST_IDLE;
      sram_addr_q   <= '0;
      sram_wdata_q  <= '0;
      sram_we_n_q   <= 1'b1;
      frame_q       <= 1'b0;
      palette_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      sram_we_n_q <= ~pop;
      if (pop) begin
        sram_addr_q  <= {~frame_q, pix_addr};
        sram_wdata_q <= head[15:0];
      end
      if (state_q == ST_FLIP) begin
        frame_q       <= ~frame_q;
        palette_sel_q <= palette_latch_q;
      end
    end
  end

  // Engine edge detection, flip request, palette latch and overflow flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      exec_prev_q     <= 1'b0;
      done_prev_q     <= 1'b0;
      flip_pending_q  <= 1'b0;
      palette_latch_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      exec_prev_q <= eng.engine_execute;
      done_prev_q <= eng.engine_done;
      if (state_q == ST_FLIP)  flip_pending_q <= 1'b0;
      else if (done_rise)      flip_pending_q <= 1'b1;
      if (exec_rise) palette_latch_q <= eng.palette_index;
      // A lost write coinciding with the clear keeps the flag set.
      if (lost)           overflow_q <= 1'b1;
      else if (exec_rise) overflow_q <= 1'b0;
    end
  end

  // Sprite source word, one cycle behind the address.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) src_data_q <= '0;
    else                src_data_q <= rom_q;
  end

endmodule
